// File: rtl/ama_riscv_ctrl_pipe_if.sv
// Decode-to-control pipeline bundle: decode fields and mode controls in,
// per-stage qualified register info and stall out.
interface ama_riscv_ctrl_pipe_if;
    logic       dec_valid;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;
    logic       dec_rd_we;
    logic       dec_rdp_we;
    logic       dec_load;
    logic       dec_mult;
    logic       hazard_to_exe;
    logic       dc_stalled;
    logic       flush_exe;
    logic [4:0] rs1_exe;
    logic [4:0] rs2_exe;
    logic [4:0] rd_mem;
    logic [4:0] rd_wbk;
    logic       rd_we_mem;
    logic       rd_we_wbk;
    logic       rdp_we_mem;
    logic       rdp_we_wbk;
    logic       load_inst_mem;
    logic       load_inst_wbk;
    logic       mult_inst_mem;
    logic       stall_dec;
    logic [15:0] bubble_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
        output dec_rd_we, dec_rdp_we, dec_load, dec_mult,
        output hazard_to_exe, dc_stalled, flush_exe,
        input  rs1_exe, rs2_exe, rd_mem, rd_wbk,
        input  rd_we_mem, rd_we_wbk, rdp_we_mem, rdp_we_wbk,
        input  load_inst_mem, load_inst_wbk, mult_inst_mem,
        input  stall_dec, bubble_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  dec_rd_we, dec_rdp_we, dec_load, dec_mult,
        input  hazard_to_exe, dc_stalled, flush_exe,
        output rs1_exe, rs2_exe, rd_mem, rd_wbk,
        output rd_we_mem, rd_we_wbk, rdp_we_mem, rdp_we_wbk,
        output load_inst_mem, load_inst_wbk, mult_inst_mem,
        output stall_dec, bubble_cnt
    );
endinterface

// File: rtl/ama_riscv_ctrl_pipe.sv
// EXE/MEM/WBK control pipeline: freeze, hazard bubble, flush and advance
// modes with a saturating hazard-bubble counter.
module ama_riscv_ctrl_pipe (
    input  logic clk,
    input  logic rst,
    ama_riscv_ctrl_pipe_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rd_we;
        logic       rdp_we;
        logic       load;
        logic       mult;
    } stage_t;

    stage_t exe_q, exe_d;
    stage_t mem_q, mem_d;
    stage_t wbk_q, wbk_d;
    stage_t dec_st;
    logic [15:0] bcnt_q, bcnt_d;
    logic        rd_nz;

    // Bubbles keep register fields so forwarding muxes see stable values
    function automatic stage_t bubble(input stage_t s);
        stage_t b;
        b        = s;
        b.valid  = 1'b0;
        b.rd_we  = 1'b0;
        b.rdp_we = 1'b0;
        b.load   = 1'b0;
        b.mult   = 1'b0;
        return b;
    endfunction

    assign rd_nz = (bus.dec_rd != 5'd0);

    always_comb begin
        dec_st        = '0;
        dec_st.valid  = bus.dec_valid;
        dec_st.rs1    = bus.dec_rs1;
        dec_st.rs2    = bus.dec_rs2;
        dec_st.rd     = bus.dec_rd;
        dec_st.rd_we  = bus.dec_rd_we && rd_nz;
        dec_st.rdp_we = bus.dec_rdp_we && rd_nz;
        dec_st.load   = bus.dec_load;
        dec_st.mult   = bus.dec_mult;
    end

    always_comb begin
        exe_d  = exe_q;
        mem_d  = mem_q;
        wbk_d  = wbk_q;
        bcnt_d = bcnt_q;
        priority case (1'b1)
            bus.dc_stalled: begin
            end
            bus.hazard_to_exe: begin
                mem_d = bubble(mem_q);
                wbk_d = mem_q;
                if (bcnt_q != 16'hFFFF)
                    bcnt_d = bcnt_q + 16'd1;
            end
            bus.flush_exe: begin
                exe_d = bubble(exe_q);
                mem_d = exe_q;
                wbk_d = mem_q;
            end
            default: begin
                exe_d = dec_st;
                mem_d = exe_q;
                wbk_d = mem_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q  <= '0;
            mem_q  <= '0;
            wbk_q  <= '0;
            bcnt_q <= '0;
        end else begin
            exe_q  <= exe_d;
            mem_q  <= mem_d;
            wbk_q  <= wbk_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign bus.rs1_exe       = exe_q.rs1;
    assign bus.rs2_exe       = exe_q.rs2;
    assign bus.rd_mem        = mem_q.rd;
    assign bus.rd_wbk        = wbk_q.rd;
    assign bus.rd_we_mem     = mem_q.rd_we && mem_q.valid;
    assign bus.rd_we_wbk     = wbk_q.rd_we && wbk_q.valid;
    assign bus.rdp_we_mem    = mem_q.rdp_we && mem_q.valid;
    assign bus.rdp_we_wbk    = wbk_q.rdp_we && wbk_q.valid;
    assign bus.load_inst_mem = mem_q.load && mem_q.valid;
    assign bus.load_inst_wbk = wbk_q.load && wbk_q.valid;
    assign bus.mult_inst_mem = mem_q.mult && mem_q.valid;
    assign bus.stall_dec     = bus.hazard_to_exe || bus.dc_stalled;
    assign bus.bubble_cnt    = bcnt_q;

endmodule

// File: doc/ama_riscv_ctrl_pipe.md
AMA_RISCV_CTRL_PIPE -- requirements
Module: ama_riscv_ctrl_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (rf_addr_t = 5 bits):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- dec_valid  in  1  decode holds a real instruction.
- dec_rs1, dec_rs2  in  rf_addr_t  decode source registers.
- dec_rd  in  rf_addr_t  decode destination register.
- dec_rd_we, dec_rdp_we  in  1  decode writes rd / paired rd.
- dec_load, dec_mult  in  1  decode instruction is a load / 2-cycle multiply.
- hazard_to_exe  in  1  EXE operand not yet available.
- dc_stalled  in  1  data cache stalled; freeze.
- flush_exe  in  1  EXE branch/jump redirect; kill the decode instruction.
- rs1_exe, rs2_exe  out  rf_addr_t  EXE source registers.
- rd_mem, rd_wbk  out  rf_addr_t  MEM/WBK destination registers.
- rd_we_mem, rd_we_wbk, rdp_we_mem, rdp_we_wbk  out  1  qualified write enables.
- load_inst_mem, load_inst_wbk, mult_inst_mem  out  1  qualified instruction class.
- stall_dec  out  1  front end SHALL hold decode.
- bubble_cnt  out  16  count of hazard bubbles inserted.

Function
REQ-003 The block SHALL hold three registered stages: EXE, MEM and WBK. Each stage SHALL hold valid, rs1, rs2, rd, rd_we, rdp_we, load and mult.
REQ-004 Capture into EXE SHALL store rd_we = dec_rd_we && dec_rd != 0 and rdp_we = dec_rdp_we && dec_rd != 0.
REQ-005 Every *_we, load_inst_* and mult_inst_mem output SHALL be the stage field ANDed with that stage's valid bit. The rd_*/rs*_exe outputs SHALL pass through raw.
REQ-006 Modes SHALL be evaluated per cycle in priority order: FREEZE, HAZARD, FLUSH, ADVANCE.
REQ-007 FREEZE (dc_stalled=1): all three stages SHALL hold, regardless of the other inputs.
REQ-008 HAZARD (hazard_to_exe=1, dc_stalled=0):
- EXE SHALL hold.
- MEM SHALL load a bubble (valid=0, all enables 0).
- WBK SHALL load MEM.
- flush_exe SHALL be ignored in this cycle.
REQ-009 FLUSH (flush_exe=1, no freeze, no hazard):
- EXE SHALL load a bubble.
- MEM SHALL load EXE.
- WBK SHALL load MEM.
REQ-010 ADVANCE (none of the above):
- EXE SHALL load the decode fields, with valid=dec_valid.
- MEM SHALL load EXE.
- WBK SHALL load MEM.
REQ-011 A bubble SHALL retain the previous rd/rs fields and clear only valid and the enables.
REQ-012 stall_dec SHALL be combinational: hazard_to_exe || dc_stalled.
REQ-013 bubble_cnt SHALL increment by 1 on each HAZARD-mode cycle and SHALL saturate at 16'hFFFF without wrapping.
REQ-014 Latency: a decode instruction SHALL appear on the EXE outputs 1 cycle after an ADVANCE edge, then on MEM +1 and WBK +1, excluding hold cycles.
REQ-015 A load in MEM followed by a dependent instruction in EXE SHALL produce exactly one bubble in MEM, provided hazard_to_exe drops after one cycle.

Reset
REQ-016 While rst=1, all stage valid bits, fields, enables and bubble_cnt SHALL be cleared to 0 on the clock edge.
REQ-017 rst SHALL take priority over all modes.
REQ-018 Mid-operation reset SHALL discard all in-flight instructions.
REQ-019 stall_dec SHALL follow its inputs during reset, since it is combinational.

Verification
REQ-020 Straight flow: three valid decode instructions with rd=5, 6, 7 and rd_we=1 -> rd_mem=5 at cycle 2 and rd_wbk=5 at cycle 3, with rd_we_* high, in order.
REQ-021 x0 write: dec_rd=0, dec_rd_we=1, dec_rdp_we=1 -> rd_we_mem=0 and rdp_we_mem=0 at all stages.
REQ-022 Load-use: load rd=3 in MEM, EXE rs1=3, hazard_to_exe for 1 cycle -> EXE held, MEM valid=0, load_inst_wbk=1, bubble_cnt=1, stall_dec=1 for that cycle.
REQ-023 Freeze: dc_stalled for 4 cycles with hazard_to_exe=1 and flush_exe=1 -> all outputs unchanged, bubble_cnt unchanged, stall_dec=1; flow resumes afterwards.
REQ-024 Flush vs hazard: flush_exe=1 with hazard_to_exe=1 -> HAZARD behaviour only. Next cycle flush_exe=1 alone -> EXE valid=0, with EXE's prior contents in MEM.
REQ-025 Saturation and reset: preload 65534 hazard cycles, then 3 more -> bubble_cnt=16'hFFFF. Assert rst with the pipe full -> all outputs 0 on the next edge.
